ramp_dac_spi: RTL

RAMP_DAC_SPI -- requirements
Module: ramp_dac_spi

---
 rtl/ramp_dac_spi.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ramp_dac_spi.sv
`default_nettype none
// ============================================================================
// Module   : ramp_dac_spi
// Function : Streams 16-bit ramp samples to a SPI DAC (mode 0, MSB first),
//            one chip-select frame per sample. Optional LDAC strobe is
//            compiled in with the macro RAMP_DAC_LDAC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ramp_dac_spi #(
    parameter int CLK_DIV   = 4,
    parameter int FRAME_GAP = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ramp,
    input  logic        en,
    output logic        busy,
    output logic        frame_done,
    output logic        dac_sclk,
    output logic        dac_cs_n,
    output logic        dac_mosi
`ifdef RAMP_DAC_LDAC_EN
    ,
    output logic        dac_ldac_n
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

`ifdef RAMP_DAC_LDAC_EN
    localparam int GAP_LEN = (FRAME_GAP > 2 * CLK_DIV) ? FRAME_GAP : 2 * CLK_DIV;
`else
    localparam int GAP_LEN = FRAME_GAP;
`endif

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [8:0] GAP_LAST = 9'(GAP_LEN - 1);
    localparam logic [8:0] LDAC_ON  = 9'(CLK_DIV);
    localparam logic [8:0] LDAC_OFF = 9'(2 * CLK_DIV);

    state_t      state_q,   state_d;
    logic [7:0]  div_q,     div_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [8:0]  gap_cnt_q, gap_cnt_d;
    logic [8:0]  gap_nxt;
    // Sample bit 15 lives in the mosi flop; this holds the remaining 15 bits.
    logic [14:0] shreg_q,   shreg_d;
    logic        sclk_q,    sclk_d;
    logic        cs_n_q,    cs_n_d;
    logic        mosi_q,    mosi_d;
    logic        busy_q,    busy_d;
    logic        done_q,    done_d;
`ifdef RAMP_DAC_LDAC_EN
    logic        ldac_n_q,  ldac_n_d;
`endif

    assign gap_nxt = gap_cnt_q + 9'd1;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        shreg_d   = shreg_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef RAMP_DAC_LDAC_EN
        ldac_n_d  = 1'b1;
`endif
        case (state_q)
            ST_IDLE: begin
                sclk_d = 1'b0;
                cs_n_d = 1'b1;
                mosi_d = 1'b0;
                busy_d = 1'b0;
                if (en) begin
                    shreg_d   = ramp[14:0];
                    cs_n_d    = 1'b0;
                    mosi_d    = ramp[15];
                    busy_d    = 1'b1;
                    div_d     = 8'd0;
                    bit_cnt_d = 4'd0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d  = 8'd0;
                    sclk_d = ~sclk_q;
                    // Data only moves on the falling toggle so it is stable at every rise.
                    if (sclk_q) begin
                        shreg_d   = {shreg_q[13:0], 1'b0};
                        mosi_d    = shreg_q[14];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd15) begin
                            cs_n_d    = 1'b1;
                            mosi_d    = 1'b0;
                            done_d    = 1'b1;
                            gap_cnt_d = 9'd0;
                            state_d   = ST_GAP;
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = 9'd0;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_nxt;
`ifdef RAMP_DAC_LDAC_EN
                    ldac_n_d  = !((gap_nxt >= LDAC_ON) && (gap_nxt < LDAC_OFF));
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            div_q     <= 8'd0;
            bit_cnt_q <= 4'd0;
            gap_cnt_q <= 9'd0;
            shreg_q   <= 15'd0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef RAMP_DAC_LDAC_EN
            ldac_n_q  <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            shreg_q   <= shreg_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef RAMP_DAC_LDAC_EN
            ldac_n_q  <= ldac_n_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign frame_done = done_q;
    assign dac_sclk   = sclk_q;
    assign dac_cs_n   = cs_n_q;
    assign dac_mosi   = mosi_q;
`ifdef RAMP_DAC_LDAC_EN
    assign dac_ldac_n = ldac_n_q;
`endif

endmodule
`default_nettype wire
